// File: rtl/wheel_speed_scheduler.sv
// -----------------------------------------------------------------------------
// wheel_speed_scheduler
//
// Purpose:
//   Periodic sampling controller for the left and right wheel encoders. Every
//   WINDOW_CYCLES clocks it latches both free-running 8-bit encoder counts and
//   forms signed per-window deltas. It then sends them over one valid/ready
//   channel, left word first and right word second. A window tick that arrives
//   while the previous window is still being latched or sent is dropped, and
//   the sticky overrun flag is raised.
//
// Ports:
//   clk            in   1  system clock
//   reset          in   1  asynchronous active-high reset
//   enable         in   1  run sampling while high
//   count_l        in   8  left encoder count (wraps mod 256)
//   count_r        in   8  right encoder count (wraps mod 256)
//   out_valid      out  1  result word available
//   out_ready      in   1  consumer accepts the word when high with out_valid
//   out_data       out  8  signed two's-complement delta for the window
//   out_sel        out  1  0 = left word, 1 = right word
//   window_id      out  8  index of the window being sent (wraps mod 256)
//   overrun        out  1  sticky: a tick arrived while not waiting
//   clear_overrun  in   1  synchronous clear of overrun (a set wins)
// -----------------------------------------------------------------------------
module wheel_speed_scheduler #(
  parameter int WINDOW_CYCLES = 500000,
  parameter int TW            = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] count_l,
  input  logic [7:0] count_r,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sel,
  output logic [7:0] window_id,
  output logic       overrun,
  input  logic       clear_overrun
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRIME  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_LATCH  = 3'd3,
    ST_SEND_L = 3'd4,
    ST_SEND_R = 3'd5
  } state_t;

  localparam logic [TW-1:0] TICK_AT = TW'(WINDOW_CYCLES - 1);

  state_t        state_r;
  state_t        next_state_s;
  logic [TW-1:0] timer_r;
  logic          running_s;
  logic          tick_s;
  logic          overrun_set_s;
  logic [7:0]    prev_left_r;
  logic [7:0]    prev_right_r;
  logic [7:0]    delta_left_r;
  logic [7:0]    delta_right_r;
  logic [7:0]    delta_left_s;
  logic [7:0]    delta_right_s;
  logic [7:0]    window_id_r;
  logic          overrun_r;
  logic          out_valid_r;
  logic          out_sel_r;
  logic [7:0]    out_data_r;
  logic          out_valid_s;
  logic          out_sel_s;
  logic [7:0]    out_data_s;

  // Timer runs only once a window has been primed; ticks are meaningful only then.
  always_comb begin
    running_s = 1'b0;
    case (state_r)
      ST_WAIT, ST_LATCH, ST_SEND_L, ST_SEND_R: running_s = 1'b1;
      default:                                 running_s = 1'b0;
    endcase
  end

  assign tick_s = running_s && (timer_r == TICK_AT);

  // A tick outside WAIT cannot be serviced: it is dropped and flagged. The
  // disable path has priority, so nothing is flagged in a cycle that aborts.
  assign overrun_set_s = enable && tick_s && (state_r != ST_WAIT);

  // Modulo-256 differences; the consumer reads them as signed -128..+127.
  assign delta_left_s  = count_l - prev_left_r;
  assign delta_right_s = count_r - prev_right_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; dropping enable aborts from any state, discarding pending words.
  always_comb begin
    next_state_s = state_r;
    if (!enable) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   next_state_s = ST_PRIME;
        ST_PRIME:  next_state_s = ST_WAIT;
        ST_WAIT:   next_state_s = tick_s ? ST_LATCH : ST_WAIT;
        ST_LATCH:  next_state_s = ST_SEND_L;
        ST_SEND_L: next_state_s = out_ready ? ST_SEND_R : ST_SEND_L;
        ST_SEND_R: next_state_s = out_ready ? ST_WAIT : ST_SEND_R;
        default:   next_state_s = ST_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state, so the channel outputs come straight
  // from flops. out_ready reaches them only through the registers. On entry to
  // SEND_L the left delta is being latched in the same edge, so the freshly
  // computed difference is used instead of the stale register.
  always_comb begin
    out_valid_s = 1'b0;
    out_sel_s   = 1'b0;
    out_data_s  = 8'h00;
    case (next_state_s)
      ST_SEND_L: begin
        out_valid_s = 1'b1;
        out_sel_s   = 1'b0;
        out_data_s  = (state_r == ST_LATCH) ? delta_left_s : delta_left_r;
      end
      ST_SEND_R: begin
        out_valid_s = 1'b1;
        out_sel_s   = 1'b1;
        out_data_s  = delta_right_r;
      end
      default: begin
        out_valid_s = 1'b0;
        out_sel_s   = 1'b0;
        out_data_s  = 8'h00;
      end
    endcase
  end

  // Output channel registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_sel_r   <= 1'b0;
      out_data_r  <= 8'h00;
    end else begin
      out_valid_r <= out_valid_s;
      out_sel_r   <= out_sel_s;
      out_data_r  <= out_data_s;
    end
  end

  // Window timer: free-runs 0..WINDOW_CYCLES-1 while running, held at 0 otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_r <= {TW{1'b0}};
    end else if (!enable || !running_s) begin
      timer_r <= {TW{1'b0}};
    end else if (tick_s) begin
      timer_r <= {TW{1'b0}};
    end else begin
      timer_r <= timer_r + TW'(1);
    end
  end

  // Count capture and delta latching. prev_* is touched only in PRIME and LATCH,
  // so a window dropped on overrun makes the next delta span several windows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_left_r   <= 8'h00;
      prev_right_r  <= 8'h00;
      delta_left_r  <= 8'h00;
      delta_right_r <= 8'h00;
      window_id_r   <= 8'h00;
    end else if (enable) begin
      case (state_r)
        ST_PRIME: begin
          prev_left_r  <= count_l;
          prev_right_r <= count_r;
        end
        ST_LATCH: begin
          delta_left_r  <= delta_left_s;
          delta_right_r <= delta_right_s;
          prev_left_r   <= count_l;
          prev_right_r  <= count_r;
          window_id_r   <= window_id_r + 8'd1;
        end
        default: begin
          prev_left_r <= prev_left_r;
        end
      endcase
    end else begin
      window_id_r <= window_id_r;
    end
  end

  // Sticky overrun flag; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_r <= 1'b0;
    end else if (overrun_set_s) begin
      overrun_r <= 1'b1;
    end else if (clear_overrun) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_sel   = out_sel_r;
  assign out_data  = out_data_r;
  assign window_id = window_id_r;
  assign overrun   = overrun_r;

endmodule
